// File: rtl/w_pulse_gen_pkg.sv
// Shared types and defaults for the w/b detector stimulus generator.
package w_pulse_gen_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/w_pulse_gen_phase_counter.sv
// Loadable down-counter that stops at zero; used for phase length and pulses remaining.
module w_pulse_gen_phase_counter
    import w_pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over decrement; the count never goes below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value  = cnt_q;
    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/w_pulse_gen.sv
// Drives a train of w pulses into a sequence detector and counts its b rising edges.
module w_pulse_gen
    import w_pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic             b,
    output logic             w,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] b_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;
    logic [CNT_W-1:0] low_len_q, low_len_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
    logic             b_prev_q, b_prev_d;
    logic             w_q, w_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ph_load, ph_en, ph_zero_c;
    logic [CNT_W-1:0] ph_val, ph_value_unused;
    logic             pl_load, pl_en, pl_zero_c;
    logic [CNT_W-1:0] pl_val, pl_value;

    w_pulse_gen_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .en       (ph_en),
        .load_val (ph_val),
        .value    (ph_value_unused),
        .zero_c   (ph_zero_c)
    );

    w_pulse_gen_phase_counter #(.CNT_W(CNT_W)) u_pulse_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pl_load),
        .en       (pl_en),
        .load_val (pl_val),
        .value    (pl_value),
        .zero_c   (pl_zero_c)
    );

    always_comb begin
        state_d    = state_q;
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        b_cnt_d    = b_cnt_q;
        b_prev_d   = b;
        ph_load    = 1'b0;
        ph_en      = 1'b0;
        ph_val     = '0;
        pl_load    = 1'b0;
        pl_en      = 1'b0;
        pl_val     = '0;
        w_d        = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        // Saturating count of b rising edges seen while the run is active.
        if (busy_q && b && !b_prev_q && (b_cnt_q != '1)) begin
            b_cnt_d = b_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    high_len_d = high_len;
                    low_len_d  = low_len;
                    b_cnt_d    = '0;
                    b_prev_d   = 1'b0;
                    ph_load    = 1'b1;
                    ph_val     = high_len - CNT_W'(1);
                    pl_load    = 1'b1;
                    pl_val     = n_pulses;
                    if ((high_len == '0) || (n_pulses == '0)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ph_zero_c) begin
                    // Pulse counter still holds this pulse; a value of 1 means it was the last.
                    pl_en = 1'b1;
                    if (low_len_q != '0) begin
                        state_d = ST_LOW;
                        ph_load = 1'b1;
                        ph_val  = low_len_q - CNT_W'(1);
                    end else if (pl_value == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        ph_load = 1'b1;
                        ph_val  = high_len_q - CNT_W'(1);
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ph_zero_c) begin
                    if (!pl_zero_c) begin
                        state_d = ST_HIGH;
                        ph_load = 1'b1;
                        ph_val  = high_len_q - CNT_W'(1);
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode.
        w_d    = (state_d == ST_HIGH);
        busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            high_len_q <= '0;
            low_len_q  <= '0;
            b_cnt_q    <= '0;
            b_prev_q   <= 1'b0;
            w_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
            b_cnt_q    <= b_cnt_d;
            b_prev_q   <= b_prev_d;
            w_q        <= w_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign w     = w_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign b_cnt = b_cnt_q;

endmodule

// File: tb/tb_w_pulse_gen.sv
// Self-checking bench for w_pulse_gen: vector table, directed corners, random runs vs a waveform model.
module tb_w_pulse_gen;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] n_pulses;
    logic             b;
    logic             w;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] b_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;

    w_pulse_gen #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .high_len (high_len),
        .low_len  (low_len),
        .n_pulses (n_pulses),
        .b        (b),
        .w        (w),
        .busy     (busy),
        .done     (done),
        .b_cnt    (b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    typedef struct {
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] n;
        int         exp_done;
        int         exp_high;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected w in cycle i (1 = first cycle after the start edge), straight from the pulse-train definition.
    function automatic logic exp_w_f(input int h, input int l, input int n, input int i);
        if (h == 0 || n == 0) return 1'b0;
        if (i < 1 || i > n * (h + l)) return 1'b0;
        return ((i - 1) % (h + l)) < h;
    endfunction

    // One run from IDLE; caller is positioned just after a rising edge.
    // b_mode: 0 random, 1 toggle every cycle, 2 held low.
    task automatic run(input int h, input int l, input int n, input int abort_at,
                       input int restart_at, input int b_mode, input logic abort_with_start,
                       output int done_cycle, output int high_cnt);
        int  len;
        int  exp_cnt;
        logic prev;
        logic rb;
        logic eb;
        logic ew;
        logic ed;
        len        = (h == 0 || n == 0) ? 0 : n * (h + l);
        exp_cnt    = 0;
        prev       = 1'b0;
        done_cycle = -1;
        high_cnt   = 0;
        high_len   = CNT_W'(h);
        low_len    = CNT_W'(l);
        n_pulses   = CNT_W'(n);
        start      = 1'b1;
        abort      = abort_with_start;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 1; i <= len + 3; i++) begin
            if (abort_at != 0 && i > abort_at) begin
                ew = 1'b0; eb = 1'b0; ed = 1'b0;
            end else begin
                ew = exp_w_f(h, l, n, i);
                eb = (i <= len);
                ed = (i == len + 1);
            end
            check("w", 32'(w), 32'(ew));
            check("busy", 32'(busy), 32'(eb));
            check("done", 32'(done), 32'(ed));
            if (w === 1'b1) high_cnt++;
            if (done === 1'b1 && done_cycle < 0) done_cycle = i;
            case (b_mode)
                0: rb = 1'($urandom_range(0, 1));
                1: rb = ~b;
                default: rb = 1'b0;
            endcase
            b = rb;
            if (eb) begin
                if (rb && !prev && exp_cnt < 255) exp_cnt++;
                prev = rb;
            end
            abort = (i == abort_at);
            start = (i == restart_at);
            high_len = CNT_W'($urandom);
            low_len  = CNT_W'($urandom);
            n_pulses = CNT_W'($urandom);
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
        end
        check("b_cnt", 32'(b_cnt), 32'(exp_cnt));
        b = 1'b0;
    endtask

    vec_t vecs[8];
    int   dc;
    int   hc;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; b = 1'b0;
        high_len = '0; low_len = '0; n_pulses = '0;
        #5;
        check("rst_w", 32'(w), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bcnt", 32'(b_cnt), 0);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_w", 32'(w), 0);
        check("idle_busy", 32'(busy), 0);

        // Abort while idle does nothing.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 0);
        check("idle_abort_done", 32'(done), 0);

        vecs[0] = '{8'd3, 8'd3, 8'd2, 13, 6};
        vecs[1] = '{8'd0, 8'd5, 8'd3, 1, 0};
        vecs[2] = '{8'd4, 8'd0, 8'd0, 1, 0};
        vecs[3] = '{8'd2, 8'd0, 8'd3, 7, 6};
        vecs[4] = '{8'd1, 8'd1, 8'd1, 3, 1};
        vecs[5] = '{8'd5, 8'd2, 8'd3, 22, 15};
        vecs[6] = '{8'd1, 8'd0, 8'd1, 2, 1};
        vecs[7] = '{8'd2, 8'd3, 8'd1, 6, 2};
        for (int v = 0; v < 8; v++) begin
            run(int'(vecs[v].h), int'(vecs[v].l), int'(vecs[v].n), 0, 0, 0, 1'b0, dc, hc);
            check("vec_done_cycle", 32'(dc), 32'(vecs[v].exp_done));
            check("vec_high_cycles", 32'(hc), 32'(vecs[v].exp_high));
        end

        // Abort in the 2nd HIGH cycle of a 4/4/5 run; a restart in cycle 1 must be ignored.
        run(4, 4, 5, 2, 1, 1, 1'b0, dc, hc);
        check("abort_no_done", 32'(dc), 32'hFFFF_FFFF);
        check("abort_high_cycles", 32'(hc), 2);

        // Start during FIN is ignored.
        run(1, 1, 1, 0, 3, 0, 1'b0, dc, hc);
        check("fin_start_done", 32'(dc), 3);

        // Start and abort together in IDLE: start wins.
        run(3, 3, 2, 0, 0, 0, 1'b1, dc, hc);
        check("start_abort_done", 32'(dc), 13);

        // Abort in the last LOW cycle beats phase completion.
        run(2, 2, 2, 8, 0, 1, 1'b0, dc, hc);
        check("abort_last_low", 32'(dc), 32'hFFFF_FFFF);

        // b toggling every cycle over a long run saturates the edge counter.
        run(255, 255, 2, 0, 0, 1, 1'b0, dc, hc);
        check("b_cnt_sat", 32'(b_cnt), 255);

        // Asynchronous reset mid-run, between edges.
        high_len = 8'd4; low_len = 8'd4; n_pulses = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = ~b;
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(busy), 1);
        check("pre_rst_bcnt_nz", 32'(b_cnt != 0), 1);
        #20 rst_n = 1'b0;
        #1;
        check("mid_rst_w", 32'(w), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_bcnt", 32'(b_cnt), 0);
        #20 rst_n = 1'b1;
        b = 1'b0;
        @(posedge clk); #1;
        check("post_rst_done", 32'(done), 0);
        run(3, 3, 2, 0, 0, 0, 1'b0, dc, hc);
        check("post_rst_run_done", 32'(dc), 13);

        // Random runs against the waveform model.
        for (int r = 0; r < 30; r++) begin
            int rh, rl, rn, len, ab, rs;
            rh  = int'($urandom_range(0, 5));
            rl  = int'($urandom_range(0, 5));
            rn  = int'($urandom_range(0, 4));
            len = (rh == 0 || rn == 0) ? 0 : rn * (rh + rl);
            ab  = 0;
            rs  = 0;
            if (len > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, len));
            if (len > 0 && $urandom_range(0, 1) == 0) begin
                rs = int'($urandom_range(1, (ab != 0) ? ab : len + 1));
            end
            run(rh, rl, rn, ab, rs, 0, 1'(r % 5 == 0), dc, hc);
            if (ab == 0) check("rand_done_cycle", 32'(dc), 32'(len + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
